apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Parametrised bus master that sits between an RV32I core's data bus and an APB3 peripheral fabric with NUM_SLV slaves. It converts a held request (busReq/busWe/busAddr/busWData) into a SETUP/ACCESS APB transfer and decodes the address to one PSEL line. It waits on PREADY, returns read data with a one-cycle busReady pulse, and reports decode misses, PSLVERR and timeouts on busErr. The core stalls on busReq && !busReady.

Parameters:
ADDR_W, 32, address width of CPU and APB side
DATA_W, 32, data width
NUM_SLV, 4, number of APB slaves (1..16)
SLV_BASE, 32'h1000_0000, base address of slave 0
SLV_SIZE_LOG2, 12, log2 of each slave window (4 KiB); slave i at SLV_BASE + i<<SLV_SIZE_LOG2
TIMEOUT, 255, max ACCESS cycles without PREADY before abort (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
busReq  in  1  CPU transfer request, held until busReady
busWe  in  1  1=write, 0=read
busAddr  in  ADDR_W  CPU byte address
busWData  in  DATA_W  CPU write data
busRData  out  DATA_W  registered read data, valid when busReady=1
busReady  out  1  one-cycle completion pulse
busErr  out  1  error flag, valid when busReady=1
PADDR  out  ADDR_W  APB address (latched)
PWDATA  out  DATA_W  APB write data (latched)
PWRITE  out  1  APB direction (latched)
PENABLE  out  1  APB enable
PSEL  out  NUM_SLV  one-hot slave select
PRDATA  in  NUM_SLV*DATA_W  slave read data, slave i at bits [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLV  per-slave ready
PSLVERR  in  NUM_SLV  per-slave error

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busRData=0, busReady=0, busErr=0, timeout counter=0.
- A reset during SETUP or ACCESS aborts the transfer. The next cycle shows all reset values and produces no busReady pulse.
- Decode: off = busAddr - SLV_BASE and idx = off >> SLV_SIZE_LOG2. A hit requires busAddr >= SLV_BASE and idx < NUM_SLV. Unsigned compare, no wrap-around aliasing.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If busReq && !busReady, latch busAddr/busWData/busWe into PADDR/PWDATA/PWRITE and latch idx.
  - Hit: go to SETUP.
  - Miss: go to RESP with err=1 and rdata=0. No PSEL is ever raised.
- SETUP (exactly 1 cycle): PSEL[idx]=1, PENABLE=0, counter cleared. Go to ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1, counter increments each cycle.
  - PREADY[idx]=1: capture PRDATA slice idx into busRData (reads only; writes leave busRData at 0), capture err=PSLVERR[idx], go to RESP.
  - Counter reaches TIMEOUT with PREADY low: go to RESP with err=1 and rdata=0.
  - PSEL and PENABLE drop in the cycle after the exit from ACCESS.
- RESP (1 cycle): busReady=1, busErr=err, busRData valid. Go to IDLE.
  - In the cycle with busReady=1 the bridge ignores busReq. The next request is sampled in the following cycle.
- busReady and busErr are high only in RESP. In every other state they are 0.
- Latency, measured from the IDLE cycle that samples busReq to busReady:
  - zero-wait slave: 3 cycles
  - each PREADY wait state: +1 cycle
  - decode miss: 1 cycle
  - timeout: TIMEOUT+2 cycles
- PADDR, PWDATA and PWRITE stay stable from SETUP through the end of ACCESS. The CPU side may change its inputs once busReady is seen.
- PREADY and PSLVERR of unselected slaves are ignored.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e
  - localparam function clog2-based IDX_W = $clog2(NUM_SLV) (min 1)
- Sub-module apb_addr_decoder: combinational; busAddr -> {hit, idx, one-hot sel}; parameters NUM_SLV, SLV_BASE, SLV_SIZE_LOG2.
- FSM, latches and timeout counter live in apb_master_bridge.

Test Plan:
- Reset then read 0x1000_1004, slave 1 PREADY=1 immediately, PRDATA1=0xDEAD_BEEF -> PSEL=4'b0010 with PENABLE=0 for 1 cycle, then PENABLE=1; busReady pulses 3 cycles after sampling with busRData=0xDEAD_BEEF, busErr=0.
- Write 0x1000_3010 data 0x1234_5678, slave 3 inserts 2 wait states -> PWRITE=1, PWDATA stable through ACCESS; busReady after 5 cycles; busErr=0; busRData=0.
- Read 0x1000_4000 (idx 4 >= NUM_SLV) and 0x0FFF_FFFC -> PSEL stays 0; busReady 1 cycle later; busErr=1, busRData=0.
- Read slave 2 with PSLVERR2=1 at PREADY -> busErr=1 with the busReady pulse; the next request proceeds normally.
- Slave 0 never asserts PREADY, TIMEOUT=8 -> PENABLE high for 8 cycles, then drops; busReady with busErr=1 at cycle 10.
- Assert rst in the second ACCESS cycle -> next cycle PSEL=0, PENABLE=0, busReady=0, state IDLE; a back-to-back request afterwards completes normally.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// Shared types and helpers for the APB master bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Slave index width; never below one bit so a single-slave build still has a vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_bridge_addr_decoder.sv
// Combinational address decode of a CPU byte address onto one of NUM_SLV windows.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int              ADDR_W        = 32,
    parameter int              NUM_SLV       = 4,
    parameter logic [ADDR_W-1:0] SLV_BASE    = 32'h1000_0000,
    parameter int              SLV_SIZE_LOG2 = 12,
    localparam int             IDX_W         = idx_width(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic               hit,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_SLV-1:0] sel
);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] win;

    // The base compare rejects addresses below the map so the subtraction cannot wrap into a window.
    always_comb begin
        off = addr - SLV_BASE;
        win = off >> SLV_SIZE_LOG2;
        hit = (addr >= SLV_BASE) && (win < ADDR_W'(NUM_SLV));
        idx = IDX_W'(win);
        sel = hit ? (NUM_SLV'(1) << idx) : '0;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// CPU data bus to APB3 master bridge: SETUP/ACCESS sequencing, decode, error and timeout reporting.
//
// state  | meaning
// IDLE   | waiting for busReq; latches request and decodes it
// SETUP  | PSEL high, PENABLE low, timeout counter cleared
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
// RESP   | one-cycle busReady pulse with busErr/busRData
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 32,
    parameter int                NUM_SLV       = 4,
    parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h1000_0000,
    parameter int                SLV_SIZE_LOG2 = 12,
    parameter int                TIMEOUT       = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      busReq,
    input  logic                      busWe,
    input  logic [ADDR_W-1:0]         busAddr,
    input  logic [DATA_W-1:0]         busWData,
    output logic [DATA_W-1:0]         busRData,
    output logic                      busReady,
    output logic                      busErr,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int               IDX_W    = idx_width(NUM_SLV);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e         state_q, state_d;
    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx, idx_q;
    logic [NUM_SLV-1:0] dec_sel, sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               pready_sel, pslverr_sel;
    logic [DATA_W-1:0]  prdata_sel;
    logic               latch_req, cnt_clr, cnt_inc, acc_done, acc_tout;

    apb_addr_decoder #(
        .ADDR_W        (ADDR_W),
        .NUM_SLV       (NUM_SLV),
        .SLV_BASE      (SLV_BASE),
        .SLV_SIZE_LOG2 (SLV_SIZE_LOG2)
    ) u_dec (
        .addr (busAddr),
        .hit  (dec_hit),
        .idx  (dec_idx),
        .sel  (dec_sel)
    );

    // Only the latched slave's handshake lines matter; the rest of the fabric is masked off.
    assign pready_sel  = |(PREADY & sel_q);
    assign pslverr_sel = |(PSLVERR & sel_q);
    assign prdata_sel  = PRDATA[int'(idx_q) * DATA_W +: DATA_W];
    assign busRData    = rdata_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, bus strobes and datapath controls.
    always_comb begin
        state_d   = state_q;
        PSEL      = '0;
        PENABLE   = 1'b0;
        busReady  = 1'b0;
        busErr    = 1'b0;
        latch_req = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        acc_done  = 1'b0;
        acc_tout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (busReq) begin
                    latch_req = 1'b1;
                    state_d   = dec_hit ? SETUP : RESP;
                end
            end
            SETUP: begin
                PSEL    = sel_q;
                cnt_clr = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = sel_q;
                PENABLE = 1'b1;
                cnt_inc = 1'b1;
                if (pready_sel) begin
                    acc_done = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    acc_tout = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                busReady = 1'b1;
                busErr   = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches, timeout counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (latch_req) begin
                PADDR   <= busAddr;
                PWDATA  <= busWData;
                PWRITE  <= busWe;
                idx_q   <= dec_idx;
                sel_q   <= dec_sel;
                err_q   <= ~dec_hit;
                rdata_q <= '0;
            end
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            if (acc_done) begin
                err_q   <= pslverr_sel;
                rdata_q <= PWRITE ? '0 : prdata_sel;
            end
            if (acc_tout) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed test of apb_master_bridge with TIMEOUT=8.
module tb_apb_master_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         busReq, busWe;
    logic [31:0]  busAddr, busWData, busRData;
    logic         busReady, busErr;
    logic [31:0]  PADDR, PWDATA;
    logic         PWRITE, PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;

    apb_master_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
        .busWData(busWData), .busRData(busRData), .busReady(busReady), .busErr(busErr),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        busReq   = 1'b1;
        busWe    = we;
        busAddr  = addr;
        busWData = wd;
    endtask

    initial begin
        rst = 1'b1; busReq = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0;
        PRDATA = '0; PREADY = '0; PSLVERR = '0;
        tick(); tick();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_ready", busReady, 0);
        chk("rst_err", busErr, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_rdata", busRData, 0);
        rst = 1'b0;
        tick();

        // Zero-wait read of slave 1
        req(1'b0, 32'h1000_1004, 32'h0);
        PREADY = 4'b0010;
        PRDATA[32 +: 32] = 32'hDEAD_BEEF;
        tick();
        chk("rd1_setup_psel", PSEL, 4'b0010);
        chk("rd1_setup_penable", PENABLE, 0);
        chk("rd1_paddr", PADDR, 32'h1000_1004);
        chk("rd1_setup_ready", busReady, 0);
        tick();
        chk("rd1_access_psel", PSEL, 4'b0010);
        chk("rd1_access_penable", PENABLE, 1);
        chk("rd1_access_ready", busReady, 0);
        tick();
        chk("rd1_ready", busReady, 1);
        chk("rd1_rdata", busRData, 32'hDEAD_BEEF);
        chk("rd1_err", busErr, 0);
        chk("rd1_psel_drop", PSEL, 0);
        chk("rd1_penable_drop", PENABLE, 0);
        busReq = 1'b0;
        tick();
        chk("rd1_ready_gone", busReady, 0);

        // Write to slave 3 with two wait states; other slaves shout ready/error
        req(1'b1, 32'h1000_3010, 32'h1234_5678);
        PREADY = 4'b0111; PSLVERR = 4'b0111;
        tick();
        chk("wr_setup_psel", PSEL, 4'b1000);
        chk("wr_pwrite", PWRITE, 1);
        chk("wr_pwdata_setup", PWDATA, 32'h1234_5678);
        busWData = 32'hFFFF_0000;
        tick();
        chk("wr_wait1_penable", PENABLE, 1);
        chk("wr_wait1_ready", busReady, 0);
        tick();
        chk("wr_wait2_penable", PENABLE, 1);
        chk("wr_wait2_ready", busReady, 0);
        chk("wr_pwdata_wait2", PWDATA, 32'h1234_5678);
        tick();
        chk("wr_wait3_penable", PENABLE, 1);
        chk("wr_wait3_ready", busReady, 0);
        PREADY = 4'b1111;
        tick();
        chk("wr_ready", busReady, 1);
        chk("wr_err", busErr, 0);
        chk("wr_rdata", busRData, 0);
        busReq = 1'b0; PREADY = '0; PSLVERR = '0;
        tick();

        // Decode misses: above the map and below the base
        req(1'b0, 32'h1000_4000, 32'h0);
        tick();
        chk("miss_hi_ready", busReady, 1);
        chk("miss_hi_err", busErr, 1);
        chk("miss_hi_rdata", busRData, 0);
        chk("miss_hi_psel", PSEL, 0);
        busReq = 1'b0;
        tick();
        chk("miss_hi_after_psel", PSEL, 0);
        req(1'b0, 32'h0FFF_FFFC, 32'h0);
        tick();
        chk("miss_lo_ready", busReady, 1);
        chk("miss_lo_err", busErr, 1);
        chk("miss_lo_psel", PSEL, 0);
        busReq = 1'b0;
        tick();

        // Slave error on slave 2, then a normal read of slave 0
        req(1'b0, 32'h1000_2008, 32'h0);
        PRDATA[64 +: 32] = 32'hCAFE_F00D;
        PREADY = 4'b0100; PSLVERR = 4'b0100;
        tick();
        chk("slverr_psel", PSEL, 4'b0100);
        tick();
        chk("slverr_penable", PENABLE, 1);
        tick();
        chk("slverr_ready", busReady, 1);
        chk("slverr_err", busErr, 1);
        req(1'b0, 32'h1000_0000, 32'h0);
        PRDATA[0 +: 32] = 32'h0000_0055;
        PREADY = 4'b0001; PSLVERR = 4'b0000;
        tick();
        chk("after_err_idle_ready", busReady, 0);
        chk("after_err_idle_psel", PSEL, 0);
        tick();
        chk("after_err_setup_psel", PSEL, 4'b0001);
        tick();
        tick();
        chk("after_err_ready", busReady, 1);
        chk("after_err_err", busErr, 0);
        chk("after_err_rdata", busRData, 32'h0000_0055);
        busReq = 1'b0; PREADY = '0;
        tick();

        // Timeout on slave 0; unselected slaves are ready
        req(1'b0, 32'h1000_0010, 32'h0);
        PREADY = 4'b1110;
        tick();
        chk("tout_setup_penable", PENABLE, 0);
        for (int i = 2; i <= 9; i++) begin
            tick();
            chk($sformatf("tout_c%0d_penable", i), PENABLE, 1);
            chk($sformatf("tout_c%0d_ready", i), busReady, 0);
        end
        tick();
        chk("tout_ready", busReady, 1);
        chk("tout_err", busErr, 1);
        chk("tout_rdata", busRData, 0);
        chk("tout_penable_drop", PENABLE, 0);
        chk("tout_psel_drop", PSEL, 0);
        busReq = 1'b0; PREADY = '0;
        tick();

        // Reset in the second ACCESS cycle, then a back-to-back request
        req(1'b0, 32'h1000_1000, 32'h0);
        tick();
        tick();
        tick();
        chk("rstmid_access_penable", PENABLE, 1);
        rst = 1'b1;
        tick();
        chk("rstmid_psel", PSEL, 0);
        chk("rstmid_penable", PENABLE, 0);
        chk("rstmid_ready", busReady, 0);
        chk("rstmid_paddr", PADDR, 0);
        rst = 1'b0;
        PREADY = 4'b0010;
        PRDATA[32 +: 32] = 32'h600D_F00D;
        tick();
        chk("b2b_setup_psel", PSEL, 4'b0010);
        chk("b2b_setup_penable", PENABLE, 0);
        chk("b2b_setup_ready", busReady, 0);
        tick();
        chk("b2b_access_ready", busReady, 0);
        tick();
        chk("b2b_ready", busReady, 1);
        chk("b2b_err", busErr, 0);
        chk("b2b_rdata", busRData, 32'h600D_F00D);
        busReq = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
